imem_banked: RTL and testbench

Parametrised, handshaked successor to the single-cycle 16-bit instruction memory. It provides a byte-addressed, little-endian word store with configurable width, depth and wait states, byte-enable writes, a request/response handshake, and a sequential hardware clear after reset. It sits between the fetch/load-store units and storage, and replaces the hard-coded reset loader.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_array.sv | 39 +++
 rtl/imem_banked.sv | 185 ++++++++++++++++++
 tb/tb_imem_banked.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and width helpers for the banked instruction memory.
// Optional hardware clear is selected with the IMEM_CLEAR_EN macro.
package imem_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int WAIT_MAX   = 15;
   localparam int WAIT_CNT_W = $clog2(WAIT_MAX + 1);

   function automatic int lanes(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int off_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W word store: one byte-enable write port, one registered read port.
// Contents are not reset; the read register only updates on a read strobe.
module imem_array
   import imem_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024
) (
   input  logic                       i_clk,
   input  logic                       i_we,
   input  logic [lanes(DATA_W)-1:0]   i_be,
   input  logic [$clog2(DEPTH)-1:0]   i_waddr,
   input  logic [DATA_W-1:0]          i_wdata,
   input  logic                       i_re,
   input  logic [$clog2(DEPTH)-1:0]   i_raddr,
   output logic [DATA_W-1:0]          o_rdata
);

   localparam int LANES = lanes(DATA_W);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < LANES; b++) begin
            if (i_be[b]) begin
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_banked.sv
// Handshaked byte-addressed little-endian word memory with wait states.
// Define IMEM_CLEAR_EN to zero the whole array sequentially after reset.
module imem_banked
   import imem_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_write,
   input  logic [ADDR_W-1:0]     i_req_addr,
   input  logic [DATA_W-1:0]     i_req_wdata,
   input  logic [DATA_W/8-1:0]   i_req_be,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_W-1:0]     o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic                  o_init_done,
   output logic [1:0]            o_dbg_state
);

   localparam int LANES = lanes(DATA_W);
   localparam int OFF_W = off_w(DATA_W);
   localparam int IDX_W = ADDR_W - OFF_W;
   localparam int AW    = $clog2(DEPTH);

   state_t                  r_state;
   state_t                  w_next;
   logic                    r_init_done;
   logic [WAIT_CNT_W-1:0]   r_wait_cnt;
   logic [AW-1:0]           r_idx;
   logic [DATA_W-1:0]       r_wdata;
   logic [LANES-1:0]        r_be;
   logic                    r_wr;
   logic                    r_err;
`ifdef IMEM_CLEAR_EN
   logic [AW-1:0]           r_clr_cnt;
`endif

   logic [IDX_W-1:0]        w_req_idx;
   logic                    w_req_err;
   logic                    w_ready;
   logic                    w_accept;
   logic                    w_last_wait;

   logic                    w_mem_we;
   logic                    w_mem_re;
   logic [LANES-1:0]        w_mem_be;
   logic [AW-1:0]           w_mem_waddr;
   logic [AW-1:0]           w_mem_raddr;
   logic [DATA_W-1:0]       w_mem_wdata;
   logic [DATA_W-1:0]       w_mem_rdata;

   // Handshake: a request is taken on a rising edge with valid and ready both high;
   // a response is consumed the same way and is held unchanged until then.
   assign w_req_idx   = i_req_addr[ADDR_W-1:OFF_W];
   assign w_req_err   = (|i_req_addr[OFF_W-1:0]) | (|(w_req_idx >> AW));
   assign w_ready     = r_init_done && (r_state == IDLE);
   assign w_accept    = i_req_valid && w_ready;
   assign w_last_wait = (r_wait_cnt == WAIT_CNT_W'(1));
   assign o_init_done = r_init_done;
   assign o_dbg_state = r_state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
`ifdef IMEM_CLEAR_EN
         r_state <= CLEAR;
`else
         r_state <= IDLE;
`endif
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
`ifdef IMEM_CLEAR_EN
         CLEAR: if (r_clr_cnt == AW'(DEPTH - 1)) w_next = IDLE;
`else
         CLEAR: w_next = IDLE;
`endif
         IDLE:  if (w_accept) w_next = (WAIT_STATES == 0) ? RESP : WAIT;
         WAIT:  if (w_last_wait) w_next = RESP;
         RESP:  if (i_rsp_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_req_ready = w_ready;
      o_rsp_valid = (r_state == RESP);
      o_rsp_err   = (r_state == RESP) && r_err;
      o_rsp_rdata = ((r_state == RESP) && !r_wr && !r_err) ? w_mem_rdata : '0;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      w_mem_be    = r_be;
      w_mem_waddr = r_idx;
      w_mem_raddr = r_idx;
      w_mem_wdata = r_wdata;
      case (r_state)
`ifdef IMEM_CLEAR_EN
         CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_be    = '1;
            w_mem_waddr = r_clr_cnt;
            w_mem_wdata = '0;
         end
`endif
         // Zero wait states: the access happens on the accept edge itself.
         IDLE: begin
            if ((WAIT_STATES == 0) && w_accept && !w_req_err) begin
               w_mem_we    = i_req_write;
               w_mem_re    = !i_req_write;
               w_mem_be    = i_req_be;
               w_mem_waddr = w_req_idx[AW-1:0];
               w_mem_raddr = w_req_idx[AW-1:0];
               w_mem_wdata = i_req_wdata;
            end
         end
         WAIT: begin
            if (w_last_wait && !r_err) begin
               w_mem_we = r_wr;
               w_mem_re = !r_wr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_init_done <= 1'b0;
         r_wait_cnt  <= '0;
         r_idx       <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_wr        <= 1'b0;
         r_err       <= 1'b0;
`ifdef IMEM_CLEAR_EN
         r_clr_cnt   <= '0;
`endif
      end else begin
`ifdef IMEM_CLEAR_EN
         if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
            if (w_next == IDLE) r_init_done <= 1'b1;
         end
`else
         r_init_done <= 1'b1;
`endif
         if (w_accept) begin
            r_idx      <= w_req_idx[AW-1:0];
            r_wdata    <= i_req_wdata;
            r_be       <= i_req_be;
            r_wr       <= i_req_write;
            r_err      <= w_req_err;
            r_wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
         end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
         end
      end
   end

   imem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .i_clk   (i_clk),
      .i_we    (w_mem_we),
      .i_be    (w_mem_be),
      .i_waddr (w_mem_waddr),
      .i_wdata (w_mem_wdata),
      .i_re    (w_mem_re),
      .i_raddr (w_mem_raddr),
      .o_rdata (w_mem_rdata)
   );

endmodule

// File: tb/tb_imem_banked.sv
// Self-checking bench for imem_banked: directed cases plus randomized traffic
// against a word-array reference model. Honours IMEM_CLEAR_EN.
module tb_imem_banked;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 1024;
   localparam int WS     = 2;
`ifdef IMEM_CLEAR_EN
   localparam int INIT_CYCLES = DEPTH;
`else
   localparam int INIT_CYCLES = 1;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_req_valid = 1'b0;
   logic              o_req_ready;
   logic              i_req_write = 1'b0;
   logic [ADDR_W-1:0] i_req_addr = '0;
   logic [DATA_W-1:0] i_req_wdata = '0;
   logic [1:0]        i_req_be = '0;
   logic              o_rsp_valid;
   logic              i_rsp_ready = 1'b0;
   logic [DATA_W-1:0] o_rsp_rdata;
   logic              o_rsp_err;
   logic              o_init_done;
   logic [1:0]        o_dbg_state;

   int checks = 0;
   int failures = 0;
   logic [DATA_W-1:0] mdl [DEPTH];
   logic [DATA_W-1:0] exp_q[$];
   logic              exp_err_q[$];

   always #5 clk = ~clk;

   imem_banked #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH), .WAIT_STATES (WS)
   ) dut (
      .i_clk (clk), .i_rst_n (rst_n),
      .i_req_valid (i_req_valid), .o_req_ready (o_req_ready),
      .i_req_write (i_req_write), .i_req_addr (i_req_addr),
      .i_req_wdata (i_req_wdata), .i_req_be (i_req_be),
      .o_rsp_valid (o_rsp_valid), .i_rsp_ready (i_rsp_ready),
      .o_rsp_rdata (o_rsp_rdata), .o_rsp_err (o_rsp_err),
      .o_init_done (o_init_done), .o_dbg_state (o_dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit addr_bad(input logic [ADDR_W-1:0] a);
      return a[0] || (int'(a >> 1) >= DEPTH);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(o_req_ready), 0);
      check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 0);
      check({tag, "_rsp_rdata"}, 32'(o_rsp_rdata), 0);
      check({tag, "_rsp_err"},   32'(o_rsp_err), 0);
      check({tag, "_init_done"}, 32'(o_init_done), 0);
   endtask

   // Called right after reset is released; samples 1 ns after each rising edge.
   task automatic wait_init(input string tag);
      int  n = 0;
      bit  early = 0;
      while (!o_init_done && n < DEPTH + 20) begin
         if (o_req_ready) early = 1;
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_init_cycles"}, 32'(n), 32'(INIT_CYCLES));
      check({tag, "_ready_early"}, 32'(early), 0);
   endtask

   // One full request/response; the response is back-pressured for 'hold' cycles.
   task automatic do_req(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [1:0] be,
                         input int hold, input bit pend, output logic [DATA_W-1:0] rdata);
      int lat;
      int n;
      bit stable;
      logic [DATA_W-1:0] cap_d;
      logic cap_e;
      logic [DATA_W-1:0] old;
      bit bad = addr_bad(addr);
      int idx = int'(addr >> 1);
      exp_err_q.push_back(bad);
      if (wr || bad) exp_q.push_back('0);
      else exp_q.push_back(mdl[idx]);
      if (wr && !bad) begin
         old = mdl[idx];
         for (int b = 0; b < 2; b++)
            if (be[b]) old[b*8 +: 8] = wdata[b*8 +: 8];
         mdl[idx] = old;
      end
      i_req_valid = 1'b1;
      i_req_write = wr;
      i_req_addr  = addr;
      i_req_wdata = wdata;
      i_req_be    = be;
      n = 0;
      while (!o_req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_accept"}, 32'(o_req_ready), 1);
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      i_req_addr  = 16'($urandom);
      i_req_wdata = 16'($urandom);
      i_req_be    = 2'($urandom);
      i_req_write = 1'($urandom);
      lat = 1;
      while (!o_rsp_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
      if (pend) begin
         i_req_valid = 1'b1;
         i_req_write = 1'b0;
         i_req_addr  = 16'h0010;
      end
      cap_d = o_rsp_rdata;
      cap_e = o_rsp_err;
      stable = 1;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if (o_rsp_rdata !== cap_d || o_rsp_err !== cap_e || o_rsp_valid !== 1'b1 ||
             o_req_ready !== 1'b0) stable = 0;
      end
      if (hold > 0) check({tag, "_held"}, 32'(stable), 1);
      check({tag, "_rdata"}, 32'(cap_d), 32'(exp_q.pop_front()));
      check({tag, "_err"}, 32'(cap_e), 32'(exp_err_q.pop_front()));
      i_rsp_ready = 1'b1;
      @(posedge clk); #1;
      i_rsp_ready = 1'b0;
      if (pend) begin
         check({tag, "_pend_ready"}, 32'({o_req_ready, o_rsp_valid}), 32'h2);
      end
      rdata = cap_d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] rd;
      logic [ADDR_W-1:0] a;
      int r;

      for (int i = 0; i < DEPTH; i++) begin
         rd = 16'($urandom);
         dut.u_array.r_mem[i] = rd;
`ifdef IMEM_CLEAR_EN
         mdl[i] = '0;
`else
         mdl[i] = rd;
`endif
      end
      #1;
      check_reset_outputs("rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_init("init");

      do_req("rd_7fe", 1'b0, 16'h07FE, 16'h0, 2'b00, 0, 0, rd);
      do_req("wr_10", 1'b1, 16'h0010, 16'h1234, 2'b11, 0, 0, rd);
      do_req("rd_10", 1'b0, 16'h0010, 16'h0, 2'b00, 0, 0, rd);
      check("rd_10_const", 32'(rd), 32'h1234);
      do_req("wr_10_hi", 1'b1, 16'h0010, 16'hABCD, 2'b10, 0, 0, rd);
      do_req("rd_10_b", 1'b0, 16'h0010, 16'h0, 2'b00, 0, 0, rd);
      check("rd_10_merge_const", 32'(rd), 32'hAB34);
      do_req("rd_mis", 1'b0, 16'h0011, 16'h0, 2'b00, 0, 0, rd);
      do_req("rd_oor", 1'b0, 16'h0800, 16'h0, 2'b00, 0, 0, rd);
      do_req("wr_mis", 1'b1, 16'h0011, 16'hFFFF, 2'b11, 0, 0, rd);
      do_req("wr_be0", 1'b1, 16'h0010, 16'h5555, 2'b00, 0, 0, rd);
      do_req("bp_rd", 1'b0, 16'h0010, 16'h0, 2'b00, 5, 1, rd);
      do_req("bp_next", 1'b0, 16'h0010, 16'h0, 2'b00, 0, 0, rd);
      check("bp_next_const", 32'(rd), 32'hAB34);

      for (int t = 0; t < 150; t++) begin
         r = $urandom_range(0, 9);
         if (r < 5)      a = 16'($urandom_range(0, 31) * 2);
         else if (r < 7) a = 16'($urandom_range(0, DEPTH - 1) * 2);
         else if (r < 8) a = 16'($urandom_range(0, 32767) * 2 + 1);
         else            a = 16'(2 * DEPTH + $urandom_range(0, 32767 - DEPTH) * 2);
         do_req("rnd", 1'($urandom), a, 16'($urandom), 2'($urandom),
                $urandom_range(0, 3), 0, rd);
      end

      // Reset while a write sits in its wait states: the write must not land.
      i_req_valid = 1'b1;
      i_req_write = 1'b1;
      i_req_addr  = 16'h0020;
      i_req_wdata = 16'hBEEF;
      i_req_be    = 2'b11;
      check("mid_rst_ready", 32'(o_req_ready), 1);
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
`ifdef IMEM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_init("reinit");
      do_req("rd_20", 1'b0, 16'h0020, 16'h0, 2'b00, 0, 0, rd);
      do_req("rd_10_after", 1'b0, 16'h0010, 16'h0, 2'b00, 0, 0, rd);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
